// File: rtl/flow_pkg.sv
// Shared sizing, clear-sequencer state encoding and downstream selector
// constants for the register bank and its channel selector/distributor.
package flow_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 20;
  localparam int SEL_W    = 5;

  // Downstream 32:1 selector and distributor share the bank geometry.
  localparam int SEL_NUM_CH = NUM_REGS;
  localparam int SEL_CH_W   = SEL_W;
  localparam int DIST_W     = DATA_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;
endpackage

// File: rtl/reg_clear_seq.sv
// Clear sequencer: walks clr_cnt over 1..NUM_REGS-1, one register per cycle,
// then drops back to idle. Register 0 is hardwired zero so it is skipped.
module reg_clear_seq #(
  parameter int NUM_REGS = flow_pkg::NUM_REGS,
  parameter int SEL_W    = flow_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic [SEL_W-1:0] clr_cnt
);
  import flow_pkg::*;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  clr_state_e       state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = SEL_W'(1);
        end
      end
      ST_CLEAR: begin
        // clr_req is ignored here; the count stops at LAST_IDX, never wraps
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_cnt  = cnt_q;
endmodule

// File: rtl/reg_bank_20x32.sv
// Register bank with one write port, two registered read ports with
// write/clear bypass, and a sequential full-bank clear. Reg 0 reads zero.
module reg_bank_20x32 #(
  parameter int NUM_REGS = flow_pkg::NUM_REGS,
  parameter int DATA_W   = flow_pkg::DATA_W,
  parameter int SEL_W    = flow_pkg::SEL_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [SEL_W-1:0]                   wr_sel,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic                               rd_req,
  input  logic [SEL_W-1:0]                   rd_sel_a,
  input  logic [SEL_W-1:0]                   rd_sel_b,
  output logic                               rd_valid,
  output logic [DATA_W-1:0]                  rd_data_a,
  output logic [DATA_W-1:0]                  rd_data_b,
  input  logic                               clr_req,
  output logic                               clr_busy,
  output logic [NUM_REGS-1:0][DATA_W-1:0]    regs_out
);
  import flow_pkg::*;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]               rd_data_b_q, rd_data_b_d;
  logic                            rd_valid_q, rd_valid_d;
  logic [SEL_W-1:0]                clr_cnt;
  logic                            wr_fire;

  reg_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_cnt  (clr_cnt)
  );

  assign wr_ready = ~clr_busy;
  assign wr_fire  = wr_valid & wr_ready;

  // Read value as it will look after this edge: new write data or a
  // register being cleared on this edge take precedence over stored data.
  function automatic logic [DATA_W-1:0] rd_view(input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] v;
    v = regs_q[sel];
    if (sel == '0)                          v = '0;
    else if (wr_fire && (wr_sel == sel))    v = wr_data;
    else if (clr_busy && (clr_cnt == sel))  v = '0;
    return v;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_fire && (wr_sel != '0)) regs_d[wr_sel] = wr_data;
    if (clr_busy)                  regs_d[clr_cnt] = '0;
    regs_d[0] = '0;
  end

  always_comb begin
    rd_valid_d  = rd_req;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_req) begin
      rd_data_a_d = rd_view(rd_sel_a);
      rd_data_b_d = rd_view(rd_sel_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      regs_q      <= regs_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign regs_out  = regs_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
endmodule

// File: tb/tb_reg_bank_20x32.sv
// Directed bench for reg_bank_20x32; read results go through a scoreboard
// queue filled when a read is issued and drained when rd_valid returns.
module tb_reg_bank_20x32;
  import flow_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            wr_valid, wr_ready;
  logic [SEL_W-1:0]                wr_sel;
  logic [DATA_W-1:0]               wr_data;
  logic                            rd_req, rd_valid;
  logic [SEL_W-1:0]                rd_sel_a, rd_sel_b;
  logic [DATA_W-1:0]               rd_data_a, rd_data_b;
  logic                            clr_req, clr_busy;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_out;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } rd_exp_t;

  rd_exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  reg_bank_20x32 dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .rd_valid  (rd_valid),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .regs_out  (regs_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
  endtask

  task automatic rd(input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sbi,
                    input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
    rd_exp_t e;
    rd_req   = 1'b1;
    rd_sel_a = sa;
    rd_sel_b = sbi;
    e.a = ea;
    e.b = eb;
    sb.push_back(e);
  endtask

  // One clock: sample #1 after the edge, drain the scoreboard, drop pulses.
  task automatic tick();
    logic    exp_rv;
    rd_exp_t e;
    exp_rv = rd_req;
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, exp_rv);
    if (exp_rv && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data_a", rd_data_a, e.a);
      chk("rd_data_b", rd_data_b, e.b);
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    clr_req  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < NUM_REGS; i++) chk(tag, regs_out[i], '0);
  endtask

  initial begin
    int busy_cycles;
    int rdy_err;

    rst = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0;
    rd_req = 1'b0; rd_sel_a = '0; rd_sel_b = '0; clr_req = 1'b0;
    #12;
    chk_all_zero("reset_regs");
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_a", rd_data_a, 0);
    chk("reset_rd_b", rd_data_b, 0);
    chk("reset_busy", clr_busy, 0);
    chk("reset_wr_ready", wr_ready, 1);
    #5 rst = 1'b0;
    tick();

    // basic write then two-port read
    wr(7, 20'h12345);
    tick();
    chk("wr7_regs_out", regs_out[7], 20'h12345);
    rd(7, 0, 20'h12345, 20'h0);
    tick();
    tick();
    chk("rd_hold_a", rd_data_a, 20'h12345);
    chk("rd_hold_b", rd_data_b, 20'h0);

    // same-edge write/read bypass
    wr(31, 20'hABCDE);
    rd(31, 7, 20'hABCDE, 20'h12345);
    tick();
    chk("wr31_regs_out", regs_out[31], 20'hABCDE);

    // writes to reg 0 are accepted and dropped
    wr(0, 20'hFFFFF);
    chk("wr0_ready", wr_ready, 1);
    tick();
    chk("wr0_regs_out", regs_out[0], 0);
    rd(0, 31, 20'h0, 20'hABCDE);
    tick();

    // fill and full clear
    for (int i = 1; i < NUM_REGS; i++) begin
      wr(SEL_W'(i), DATA_W'(i));
      tick();
    end
    chk("fill_1", regs_out[1], 1);
    chk("fill_31", regs_out[31], 31);
    clr_req = 1'b1;
    tick();
    busy_cycles = 0;
    rdy_err     = 0;
    for (int k = 0; k < 40; k++) begin
      if (!clr_busy) break;
      busy_cycles++;
      if (wr_ready !== 1'b0) rdy_err++;
      if (k == 4)  rd(5, 20, 20'h0, 20'd20);
      if (k == 10) clr_req = 1'b1;
      if (k == 12) wr(2, 20'h00777);
      tick();
    end
    chk("clr_busy_cycles", busy_cycles, NUM_REGS - 1);
    chk("clr_wr_ready_low", rdy_err, 0);
    chk_all_zero("clr_regs");
    chk("clr_done_ready", wr_ready, 1);
    tick();
    chk("clr_no_restart", clr_busy, 0);

    // write and clear requested on the same edge
    wr(3, 20'h00055);
    clr_req = 1'b1;
    tick();
    chk("wc_reg3_first", regs_out[3], 20'h00055);
    chk("wc_busy", clr_busy, 1);
    tick();
    tick();
    chk("wc_reg3_kept", regs_out[3], 20'h00055);
    tick();
    chk("wc_reg3_zeroed", regs_out[3], 0);
    for (int k = 0; k < 40 && clr_busy; k++) tick();
    chk("wc_clear_done", clr_busy, 0);

    // asynchronous reset in the middle of a clear
    wr(9, 20'h99999);
    clr_req = 1'b1;
    tick();
    rd(9, 1, 20'h99999, 20'h0);
    tick();
    tick();
    chk("pre_rst_busy", clr_busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", clr_busy, 0);
    chk("arst_wr_ready", wr_ready, 1);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_a", rd_data_a, 0);
    chk("arst_rd_b", rd_data_b, 0);
    chk_all_zero("arst_regs");
    sb.delete();
    #2 rst = 1'b0;
    tick();
    chk("post_rst_idle", clr_busy, 0);
    chk("post_rst_ready", wr_ready, 1);
    chk_all_zero("post_rst_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
